// File: rtl/data_table_rd_arb.sv
// -----------------------------------------------------------------------------
// data_table_rd_arb
//
// Responder side of the data-table read interface. One data-table RAM read
// port is shared by CLIENTS_CNT chain walkers (search/insert/delete engines).
// The port is offered round-robin to clients that have no read in flight.
// An accepted offer becomes a RAM read. A valid/id pipe, RAM_LATENCY deep,
// follows each read through the fixed RAM latency, so the response goes back
// only to the client that issued it.
//
// Optional build feature (macro DATA_TABLE_RD_ARB_OUT_REG_EN):
//   defined   - rd_data_o / rd_data_val_o are registered; latency RAM_LATENCY+1
//   undefined - combinational response path; latency RAM_LATENCY
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   rd_avail_o     per-client port offer (one-hot or zero)
//   rd_en_i        per-client read strobe
//   rd_addr_i      per-client read address, client i at [i*A_WIDTH +: A_WIDTH]
//   rd_data_o      response data, broadcast to all clients
//   rd_data_val_o  per-client response valid (one-hot or zero)
//   ram_busy_i     RAM port held by the table writer; no new reads are issued
//   ram_rd_en_o    RAM read enable
//   ram_rd_addr_o  RAM read address
//   ram_rd_data_i  RAM read data
//   proto_err_o    sticky flag: a client strobed rd_en without an offer
// -----------------------------------------------------------------------------
module data_table_rd_arb #(
    parameter int CLIENTS_CNT = 4,
    parameter int A_WIDTH     = 10,
    parameter int D_WIDTH     = 32,
    parameter int RAM_LATENCY = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    output logic [CLIENTS_CNT-1:0]         rd_avail_o,
    input  logic [CLIENTS_CNT-1:0]         rd_en_i,
    input  logic [CLIENTS_CNT*A_WIDTH-1:0] rd_addr_i,
    output logic [D_WIDTH-1:0]             rd_data_o,
    output logic [CLIENTS_CNT-1:0]         rd_data_val_o,
    input  logic                           ram_busy_i,
    output logic                           ram_rd_en_o,
    output logic [A_WIDTH-1:0]             ram_rd_addr_o,
    input  logic [D_WIDTH-1:0]             ram_rd_data_i,
    output logic                           proto_err_o
);

    localparam int ID_W = $clog2(CLIENTS_CNT);

    typedef logic [D_WIDTH-1:0] ram_data_t;

    typedef struct packed {
        logic            val;
        logic [ID_W-1:0] id;
    } pipe_t;

    logic [ID_W-1:0]        ptr;
    logic [CLIENTS_CNT-1:0] outstanding;
    pipe_t                  pipe [RAM_LATENCY];
    logic                   proto_err;

    logic                   offer_found;
    logic [ID_W-1:0]        offer_idx;
    logic                   offer_valid;
    logic [CLIENTS_CNT-1:0] offer_mask;
    logic [CLIENTS_CNT-1:0] issue_mask;
    logic                   issue;
    logic                   violation;
    logic [CLIENTS_CNT-1:0] resp_mask;
    logic [CLIENTS_CNT-1:0] clear_mask;
    pipe_t                  pipe_last;

    // Round-robin scan: first client without an outstanding read, starting at ptr.
    // NOTE: every variable written here is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin : offer_scan
        int              idx;
        logic [ID_W-1:0] cand;
        offer_found = 1'b0;
        offer_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < CLIENTS_CNT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CLIENTS_CNT) begin
                idx = idx - CLIENTS_CNT;
            end
            cand = ID_W'(idx);
            if (!offer_found && !outstanding[cand]) begin
                offer_found = 1'b1;
                offer_idx   = cand;
            end
        end
    end

    // No offer while the writer owns the RAM, or during reset. The reset gate
    // keeps the outputs quiet during the reset cycle itself.
    assign offer_valid = offer_found && !ram_busy_i && !rst_i;

    always_comb begin
        offer_mask = '0;
        if (offer_valid) begin
            offer_mask[offer_idx] = 1'b1;
        end
    end

    assign rd_avail_o  = offer_mask;
    assign issue_mask  = rd_en_i & offer_mask;
    assign issue       = |issue_mask;
    // A strobe without an offer is dropped here and only raises the flag.
    assign violation   = |(rd_en_i & ~offer_mask);
    assign ram_rd_en_o = issue;

    always_comb begin
        ram_rd_addr_o = '0;
        for (int i = 0; i < CLIENTS_CNT; i++) begin
            if (offer_idx == ID_W'(i)) begin
                ram_rd_addr_o = rd_addr_i[i*A_WIDTH +: A_WIDTH];
            end
        end
    end

    assign pipe_last = pipe[RAM_LATENCY-1];

    always_comb begin
        resp_mask = '0;
        for (int i = 0; i < CLIENTS_CNT; i++) begin
            resp_mask[i] = pipe_last.val && (pipe_last.id == ID_W'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // The latency pipe is reset as well: a stale valid left in it would
    // deliver a response to a client that no longer expects one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr         <= '0;
            outstanding <= '0;
            proto_err   <= 1'b0;
            for (int k = 0; k < RAM_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            // ptr moves past any offered client, accepted or not.
            if (offer_valid) begin
                ptr <= (offer_idx == ID_W'(CLIENTS_CNT-1)) ? '0 : offer_idx + 1'b1;
            end
            // Issue and clear never target the same client: an issue needs
            // outstanding=0 and a clear needs outstanding=1.
            outstanding <= (outstanding & ~clear_mask) | issue_mask;
            pipe[0]     <= '{val: issue, id: offer_idx};
            for (int k = 1; k < RAM_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
            if (violation) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign proto_err_o = proto_err;

`ifdef DATA_TABLE_RD_ARB_OUT_REG_EN
    ram_data_t              data_q;
    logic [CLIENTS_CNT-1:0] val_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            val_q  <= '0;
        end else begin
            data_q <= ram_rd_data_i;
            val_q  <= resp_mask;
        end
    end

    // The client stays ineligible until it has actually seen its registered valid.
    assign clear_mask    = val_q;
    assign rd_data_o     = data_q;
    assign rd_data_val_o = val_q & {CLIENTS_CNT{!rst_i}};
`else
    assign clear_mask    = resp_mask;
    assign rd_data_o     = ram_rd_data_i;
    assign rd_data_val_o = resp_mask & {CLIENTS_CNT{!rst_i}};
`endif

endmodule
